lc3_mem_io_unit: RTL
====================

// Module: lc3_mem_io_unit
// PURPOSE
//  Memory/IO access unit at the far end of the LC-3 address path: holds MAR and MDR, decodes
//  the MAR address into main memory or memory-mapped device registers, runs the access, and
//  returns the ready flag R to the control FSM. Main memory is external, variable latency, req/ack.
//  Owns KBSR/KBDR, DSR/DDR and MCR.
// PARAMETERS
//  IO_BASE    16'hFE00  first device address; MAR >= IO_BASE is device space, else memory
//  MCR_RESET  16'h8000  MCR reset value (bit15 = clock enable)
// PORTS
//  i_clk         in   1   system clock, all state on rising edge
//  i_rst_n       in   1   asynchronous, active-low reset
//  i_bus         in   16  processor bus (MarMux/ALU/PC value via gates)
//  i_LD_MAR      in   1   load MAR from i_bus
//  i_LD_MDR      in   1   load MDR (source chosen by i_MIO_EN/i_R_W)
//  i_MIO_EN      in   1   request memory/IO access at MAR
//  i_R_W         in   1   1 = write MDR to MAR, 0 = read
//  o_MAR         out  16  MAR contents
//  o_MDR         out  16  MDR contents
//  o_R           out  1   access complete, one-cycle pulse
//  o_mem_req     out  1   memory request, held until ack
//  o_mem_we      out  1   1 = memory write
//  o_mem_addr    out  16  memory address, stable while o_mem_req
//  o_mem_wdata   out  16  memory write data, stable while o_mem_req
//  i_mem_rdata   in   16  memory read data, valid with i_mem_ack
//  i_mem_ack     in   1   memory completion, one cycle
//  i_kb_valid    in   1   keyboard character strobe
//  i_kb_data     in   8   keyboard character
//  o_dsp_valid   out  1   display character valid
//  o_dsp_data    out  8   display character
//  i_dsp_ready   in   1   display accepts when valid & ready
//  o_clk_en      out  1   MCR[15]
// BEHAVIOUR
//  Reset (async, immediate): MAR=0, MDR=0, FSM=IDLE, o_R=0, o_mem_req=0, o_mem_we=0,
//   o_mem_addr=0, o_mem_wdata=0, KBSR=0, KBDR=0, DSR=16'h8000, o_dsp_valid=0, o_dsp_data=0,
//   MCR=MCR_RESET. Reset mid-access drops o_mem_req at once; access is abandoned, no R.
//  MAR: i_LD_MAR -> MAR<=i_bus at edge, any state. MDR: i_LD_MDR & !i_MIO_EN -> MDR<=i_bus;
//   i_LD_MDR & i_MIO_EN & !i_R_W & o_R -> MDR<=rdata_q; other i_LD_MDR combinations: no change.
//  FSM IDLE/MEM_WAIT/DONE; o_R=1 only in DONE (exactly one cycle).
//   IDLE, i_MIO_EN=1, MAR<IO_BASE: latch o_mem_addr=MAR, o_mem_wdata=MDR, o_mem_we=i_R_W,
//    o_mem_req=1 -> MEM_WAIT. Later MAR/MDR changes do not affect the in-flight request.
//   MEM_WAIT: i_mem_ack -> rdata_q<=i_mem_rdata (reads), o_mem_req=0 -> DONE; else hold.
//   IDLE, i_MIO_EN=1, MAR>=IO_BASE: device access performed at this edge -> DONE (latency 1).
//   DONE -> IDLE always; i_MIO_EN still high in IDLE starts a new access (back-to-back legal).
//   Memory latency: R asserted the cycle after i_mem_ack (min 2 cycles after start).
//  Device map (reads return rdata_q; unmapped in device space: read 0, write ignored):
//   xFE00 KBSR {ready,IE,14'b0}; write updates IE (bit14) only.
//   xFE02 KBDR {8'b0,char}; read clears KBSR[15].
//   xFE04 DSR  {ready,IE,14'b0}; write updates IE only.
//   xFE06 DDR  write while DSR[15]=1: o_dsp_data<=MDR[7:0], o_dsp_valid=1, DSR[15]=0;
//              write while DSR[15]=0: ignored. Read returns {8'b0,o_dsp_data}.
//   xFFFE MCR  full 16-bit read/write; o_clk_en=MCR[15].
//  Keyboard: i_kb_valid & KBSR[15]=0 -> KBDR<=i_kb_data, KBSR[15]=1; while full: char dropped.
//   Same-edge KBDR read and i_kb_valid: read returns old char, new char loaded, KBSR[15] stays 1.
//  Display: o_dsp_valid & i_dsp_ready at edge -> o_dsp_valid=0, DSR[15]=1. Valid holds till ready.
// TESTING
//  1 Reset mid-MEM_WAIT (i_rst_n low, no ack) -> o_mem_req=0 same cycle, MCR=8000, DSR=8000, no o_R.
//  2 MAR=3000, MIO_EN read, ack after 3 cycles rdata=1234, LD_MDR in R cycle -> MDR=1234, one R pulse.
//  3 MAR=3001, MDR=ABCD, write; change MAR/MDR during wait -> o_mem_addr=3001, wdata=ABCD, we=1 held.
//  4 kb_valid 'A'(41) then 'B' -> KBSR=8000, KBDR=0041 ('B' dropped); read FE02 -> MDR=0041, KBSR=0.
//  5 Write FE06 MDR=0048 -> dsp_valid=1,data=48,DSR=0; 2nd write ignored; ready -> DSR=8000, valid=0.
//  6 Write FFFE MDR=0000 -> o_clk_en=0; read FE00/FF00 in device space -> R after 1 cycle, MDR=0000.

Source files
------------

// File: rtl/lc3_mem_io_unit.sv
// lc3_mem_io_unit: LC-3 MAR/MDR, memory req/ack handshake and memory-mapped keyboard/display/MCR registers.
module lc3_mem_io_unit #(
    parameter logic [15:0] IO_BASE   = 16'hFE00,
    parameter logic [15:0] MCR_RESET = 16'h8000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_bus,
    input  logic        i_LD_MAR,
    input  logic        i_LD_MDR,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    output logic [15:0] o_MAR,
    output logic [15:0] o_MDR,
    output logic        o_R,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data,
    input  logic        i_dsp_ready,
    output logic        o_clk_en
);
    localparam logic [15:0] KBSR_A = 16'hFE00;
    localparam logic [15:0] KBDR_A = 16'hFE02;
    localparam logic [15:0] DSR_A  = 16'hFE04;
    localparam logic [15:0] DDR_A  = 16'hFE06;
    localparam logic [15:0] MCR_A  = 16'hFFFE;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0] rdata_q, mcr, dev_rd;
    logic [7:0]  kbdr;
    logic        kb_rdy, kb_ie, dsr_rdy, dsr_ie;
    logic        start, dev_acc, mem_start, dev_wr, kbdr_rd, kb_take, ddr_wr, dsp_fire;

    assign o_R      = state == DONE;
    assign o_clk_en = mcr[15];

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        start     = state == IDLE && i_MIO_EN;
        dev_acc   = start && o_MAR >= IO_BASE;
        mem_start = start && o_MAR < IO_BASE;
        dev_wr    = dev_acc && i_R_W;
        kbdr_rd   = dev_acc && !i_R_W && o_MAR == KBDR_A;
        // a KBDR read frees the buffer on the same edge, so a coincident strobe is accepted
        kb_take   = i_kb_valid && (!kb_rdy || kbdr_rd);
        ddr_wr    = dev_wr && o_MAR == DDR_A && dsr_rdy;
        dsp_fire  = o_dsp_valid && i_dsp_ready;
        dev_rd    = o_MAR == KBSR_A ? {kb_rdy, kb_ie, 14'b0} :
                    o_MAR == KBDR_A ? {8'b0, kbdr} :
                    o_MAR == DSR_A  ? {dsr_rdy, dsr_ie, 14'b0} :
                    o_MAR == DDR_A  ? {8'b0, o_dsp_data} :
                    o_MAR == MCR_A  ? mcr : 16'b0;
        state_nxt = dev_acc ? DONE :
                    mem_start ? MEM_WAIT :
                    (state == MEM_WAIT && i_mem_ack) ? DONE :
                    state == DONE ? IDLE : state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_MAR       <= '0;
            o_MDR       <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            rdata_q     <= '0;
            kb_rdy      <= 1'b0;
            kb_ie       <= 1'b0;
            kbdr        <= '0;
            dsr_rdy     <= 1'b1;
            dsr_ie      <= 1'b0;
            o_dsp_valid <= 1'b0;
            o_dsp_data  <= '0;
            mcr         <= MCR_RESET;
        end else begin
            if (i_LD_MAR) o_MAR <= i_bus;
            if (i_LD_MDR && !i_MIO_EN) o_MDR <= i_bus;
            else if (i_LD_MDR && !i_R_W && o_R) o_MDR <= rdata_q;
            // request fields are captured once so MAR/MDR may change while memory is busy
            if (mem_start) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_R_W;
                o_mem_addr  <= o_MAR;
                o_mem_wdata <= o_MDR;
            end
            if (state == MEM_WAIT && i_mem_ack) begin
                o_mem_req <= 1'b0;
                if (!o_mem_we) rdata_q <= i_mem_rdata;
            end
            if (dev_acc && !i_R_W) rdata_q <= dev_rd;
            if (dev_wr && o_MAR == KBSR_A) kb_ie <= o_MDR[14];
            if (dev_wr && o_MAR == DSR_A) dsr_ie <= o_MDR[14];
            if (dev_wr && o_MAR == MCR_A) mcr <= o_MDR;
            if (kb_take) kbdr <= i_kb_data;
            kb_rdy <= kb_take || (kb_rdy && !kbdr_rd);
            if (ddr_wr) o_dsp_data <= o_MDR[7:0];
            dsr_rdy     <= !ddr_wr && (dsr_rdy || dsp_fire);
            o_dsp_valid <= ddr_wr || (o_dsp_valid && !i_dsp_ready);
        end
    end
endmodule
